fir_stream_ctrl: RTL and testbench

Sequencer that streams a block of 8-bit audio samples from a synchronous-read sample memory into the FIR filter datapath. It clears the filter, feeds samples and then zero flush samples, and tags each 16-bit filter output with a valid strobe aligned to the filter latency. It signals completion and replaces the free-running testbench feed loop with a start/busy/done handshake usable in hardware.

---
 rtl/fir_stream_ctrl_if.sv | 29 ++
 rtl/fir_stream_ctrl.sv | 149 ++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fir_stream_ctrl_if.sv
// rtl/fir_stream_ctrl_if.sv - control handshake, sample memory, filter and output signals of fir_stream_ctrl
interface fir_stream_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 14
);
  logic              start;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              filt_clr;
  logic [7:0]        filt_x;
  logic [15:0]       filt_y;
  logic [15:0]       out_data;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, mem_data, filt_y,
    output mem_rd_en, mem_addr, filt_clr, filt_x, out_data, out_valid, out_count, busy, done
  );

  modport slave (
    output start, abort, mem_data, filt_y,
    input  mem_rd_en, mem_addr, filt_clr, filt_x, out_data, out_valid, out_count, busy, done
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - block sequencer feeding memory samples plus zero flush into the FIR datapath
module fir_stream_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int NUM_SAMPLES = 7585,
  parameter int FLUSH_LEN   = 8,
  parameter int PIPE_LAT    = 3,
  parameter int CNT_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  fir_stream_ctrl_if.master bus
);
  localparam int FCNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [FCNT_W-1:0] LAST_FLUSH = FCNT_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DRAIN, DONE} state_t;

  state_t              state;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic                feed_v;
  logic                feed_d;
  logic                rd_valid_d;
  logic                in_valid;
  logic [7:0]          filt_x;
  logic                filt_clr;
  logic                busy;
  logic                done;
  logic [FCNT_W-1:0]   flush_cnt;
  logic [PIPE_LAT-1:0] dly;
  logic [PIPE_LAT-1:0] dly_next;
  logic [CNT_W-1:0]    out_count;
  logic                kill;
  logic                drained;

  assign kill     = bus.abort && (state != IDLE);
  assign dly_next = PIPE_LAT'({dly, in_valid});
  // Drained once the output now leaving is the last one: nothing queued behind it.
  assign drained  = (dly_next == '0) && !feed_d && !feed_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      feed_v    <= 1'b0;
      flush_cnt <= '0;
      filt_clr  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_count <= '0;
    end else if (kill) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      feed_v    <= 1'b0;
      filt_clr  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (dly[PIPE_LAT-1]) out_count <= out_count + CNT_W'(1);
      case (state)
        IDLE: begin
          filt_clr <= 1'b0;
          if (bus.start) begin
            state    <= CLEAR;
            filt_clr <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= RUN;
          filt_clr  <= 1'b0;
          mem_rd_en <= 1'b1;
          mem_addr  <= '0;
          feed_v    <= 1'b1;
          out_count <= '0;
        end
        RUN: begin
          if (mem_addr == LAST_ADDR) begin
            mem_rd_en <= 1'b0;
            flush_cnt <= '0;
            if (FLUSH_LEN > 0) begin
              state <= FLUSH;
            end else begin
              state  <= DRAIN;
              feed_v <= 1'b0;
            end
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == LAST_FLUSH) begin
            state  <= DRAIN;
            feed_v <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + FCNT_W'(1);
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (bus.start) begin
            state    <= CLEAR;
            filt_clr <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush samples ride the same two-stage feed path as memory reads, so they follow without a gap.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      feed_d     <= 1'b0;
      rd_valid_d <= 1'b0;
      in_valid   <= 1'b0;
      filt_x     <= '0;
      dly        <= '0;
    end else begin
      feed_d     <= feed_v;
      rd_valid_d <= mem_rd_en;
      in_valid   <= feed_d;
      filt_x     <= rd_valid_d ? bus.mem_data : 8'h00;
      dly        <= dly_next;
    end
  end

  assign bus.mem_rd_en = mem_rd_en;
  assign bus.mem_addr  = mem_addr;
  assign bus.filt_clr  = filt_clr;
  assign bus.filt_x    = filt_x;
  assign bus.out_data  = bus.filt_y;
  assign bus.out_valid = dly[PIPE_LAT-1];
  assign bus.out_count = out_count;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - directed bench for fir_stream_ctrl with memory, filter model and output scoreboard
module tb_fir_stream_ctrl;
  logic clk;
  logic rst;

  fir_stream_ctrl_if #(.ADDR_W(13), .CNT_W(14)) ifa ();
  fir_stream_ctrl_if #(.ADDR_W(13), .CNT_W(14)) ifb ();

  fir_stream_ctrl #(.ADDR_W(13), .NUM_SAMPLES(8), .FLUSH_LEN(2), .PIPE_LAT(3), .CNT_W(14)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  fir_stream_ctrl #(.ADDR_W(13), .NUM_SAMPLES(8), .FLUSH_LEN(0), .PIPE_LAT(3), .CNT_W(14)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory holds 1..8; filter is three registers of filt_x, cleared by filt_clr.
  logic [7:0] fa1, fa2, fa3, fb1, fb2, fb3;
  always @(posedge clk) begin
    if (ifa.mem_rd_en) ifa.mem_data <= 8'(ifa.mem_addr) + 8'd1;
    if (ifb.mem_rd_en) ifb.mem_data <= 8'(ifb.mem_addr) + 8'd1;
    if (ifa.filt_clr) begin
      fa1 <= 8'h00; fa2 <= 8'h00; fa3 <= 8'h00;
    end else begin
      fa1 <= ifa.filt_x; fa2 <= fa1; fa3 <= fa2;
    end
    if (ifb.filt_clr) begin
      fb1 <= 8'h00; fb2 <= 8'h00; fb3 <= 8'h00;
    end else begin
      fb1 <= ifb.filt_x; fb2 <= fb1; fb3 <= fb2;
    end
  end
  assign ifa.filt_y = {8'h00, fa3};
  assign ifb.filt_y = {8'h00, fb3};

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] vec_a();
    return {ifa.filt_clr, ifa.busy, ifa.mem_rd_en, ifa.out_valid, ifa.done, ifa.filt_x};
  endfunction

  function automatic logic [12:0] vec_b();
    return {ifb.filt_clr, ifb.busy, ifb.mem_rd_en, ifb.out_valid, ifb.done, ifb.filt_x};
  endfunction

  always @(negedge clk) begin
    if (ifa.out_valid) begin
      chk("sb_a_pending", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk("sb_a_data", ifa.out_data, qa.pop_front());
    end
    if (ifb.out_valid) begin
      chk("sb_b_pending", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) chk("sb_b_data", ifb.out_data, qb.pop_front());
    end
  end

  task automatic launch(input bit b, input bit push);
    @(negedge clk);
    if (b) ifb.start = 1'b1;
    else   ifa.start = 1'b1;
    if (push) begin
      for (int i = 1; i <= (b ? 8 : 10); i++) begin
        if (b) qb.push_back(16'((i <= 8) ? i : 0));
        else   qa.push_back(16'((i <= 8) ? i : 0));
      end
    end
    @(posedge clk);
  endtask

  // Cycle c after the edge that sampled start; checks control timing and filt_x per cycle.
  task automatic run_block(input bit b, input bit hold);
    int tot;
    logic [7:0]  ex;
    logic [12:0] expv;
    tot = b ? 8 : 10;
    for (int c = 1; c <= tot + 7; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) begin
        if (b) ifb.start = 1'b0;
        else   ifa.start = 1'b0;
      end
      ex   = (c >= 4 && c <= 11) ? 8'(c - 3) : 8'h00;
      expv = {c == 1, c <= tot + 6, c >= 2 && c <= 9, c >= 7 && c <= tot + 6, c == tot + 7, ex};
      chk($sformatf("blk%0d_ctl_c%0d", b, c), b ? vec_b() : vec_a(), expv);
      if (c >= 2 && c <= 9) chk($sformatf("blk%0d_addr_c%0d", b, c), b ? ifb.mem_addr : ifa.mem_addr, c - 2);
      if (c == 2) chk("blk_count_clr", b ? ifb.out_count : ifa.out_count, 0);
    end
    chk("blk_count_end", b ? ifb.out_count : ifa.out_count, tot);
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl_a", vec_a(), 13'h1000);
    chk("rst_addr_a", ifa.mem_addr, 0);
    chk("rst_count_a", ifa.out_count, 0);
    chk("rst_ctl_b", vec_b(), 13'h1000);
    rst = 1'b0;
    @(negedge clk);
    chk("clr_release", vec_a(), 13'h0000);
    repeat (4) @(negedge clk);

    launch(0, 1);
    run_block(0, 0);

    launch(0, 1);
    run_block(0, 1);
    for (int i = 1; i <= 10; i++) qa.push_back(16'((i <= 8) ? i : 0));
    run_block(0, 0);

    launch(0, 0);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (4) @(negedge clk);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    chk("abort_ctl", vec_a(), 13'h0000);
    chk("abort_count", ifa.out_count, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_quiet", vec_a(), 13'h0000);
    end
    launch(0, 1);
    run_block(0, 0);

    launch(0, 1);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstf_ctl", vec_a(), 13'h1000);
      chk("rstf_addr", ifa.mem_addr, 0);
      chk("rstf_count", ifa.out_count, 0);
    end
    rst = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("rstf_release", vec_a(), 13'h0000);
    launch(0, 1);
    run_block(0, 0);

    launch(1, 1);
    run_block(1, 0);

    repeat (3) @(negedge clk);
    chk("sb_a_empty", qa.size(), 0);
    chk("sb_b_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
